// File: rtl/vm_dispatch.sv
// Round-robin dispatcher connecting one snooper and one forwarder to N_VMS bpfvm instances.
// Each side has its own grant FSM; a grant is held from arbitration until that side's done pulse.

module vm_dispatch_arb #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  ready_i,
  input  logic          done_i,
  output logic          grant_o,
  output logic [SW-1:0] sel_o,
  output logic [31:0]   count_o
);
  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]   count_q, count_d;
  logic          found;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    found    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // First ready VM at or after rr_ptr, wrapping upward.
        for (int i = 0; i < N; i++) begin
          if (!found && ready_i[(int'(rr_ptr_q) + i) % N]) begin
            found = 1'b1;
            sel_d = SW'((int'(rr_ptr_q) + i) % N);
          end
        end
        if (found) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (done_i) begin
          state_d  = S_IDLE;
          rr_ptr_d = (sel_q == SW'(N - 1)) ? '0 : sel_q + 1'b1;
          count_d  = count_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign grant_o = (state_q == S_GRANT);
  assign sel_o   = sel_q;
  assign count_o = count_q;
endmodule

module vm_dispatch #(
  parameter int N_VMS                = 4,
  parameter int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH           = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [SNOOP_FWD_ADDR_WIDTH-1:0]       snooper_wr_addr,
  input  logic [DATA_WIDTH-1:0]                 snooper_wr_data,
  input  logic                                  snooper_wr_en,
  input  logic                                  snooper_done,
  output logic                                  ready_for_snooper,
  input  logic [SNOOP_FWD_ADDR_WIDTH-1:0]       forwarder_rd_addr,
  input  logic                                  forwarder_rd_en,
  input  logic                                  forwarder_done,
  output logic [DATA_WIDTH-1:0]                 forwarder_rd_data,
  output logic                                  ready_for_forwarder,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0]       len_to_forwarder,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0]       vm_snooper_wr_addr,
  output logic [DATA_WIDTH-1:0]                 vm_snooper_wr_data,
  output logic [N_VMS-1:0]                      vm_snooper_wr_en,
  output logic [N_VMS-1:0]                      vm_snooper_done,
  input  logic [N_VMS-1:0]                      vm_ready_for_snooper,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0]       vm_forwarder_rd_addr,
  output logic [N_VMS-1:0]                      vm_forwarder_rd_en,
  output logic [N_VMS-1:0]                      vm_forwarder_done,
  input  logic [N_VMS*DATA_WIDTH-1:0]           vm_forwarder_rd_data,
  input  logic [N_VMS*SNOOP_FWD_ADDR_WIDTH-1:0] vm_len_to_forwarder,
  input  logic [N_VMS-1:0]                      vm_ready_for_forwarder,
  output logic [31:0]                           dispatch_count,
  output logic [31:0]                           forward_count
);
  localparam int SW = (N_VMS > 1) ? $clog2(N_VMS) : 1;

  logic          s_grant, f_grant;
  logic [SW-1:0] s_sel, f_sel;

  vm_dispatch_arb #(.N(N_VMS), .SW(SW)) u_snoop_arb (
    .clk     (clk),
    .rst     (rst),
    .ready_i (vm_ready_for_snooper),
    .done_i  (snooper_done),
    .grant_o (s_grant),
    .sel_o   (s_sel),
    .count_o (dispatch_count)
  );

  vm_dispatch_arb #(.N(N_VMS), .SW(SW)) u_fwd_arb (
    .clk     (clk),
    .rst     (rst),
    .ready_i (vm_ready_for_forwarder),
    .done_i  (forwarder_done),
    .grant_o (f_grant),
    .sel_o   (f_sel),
    .count_o (forward_count)
  );

  assign ready_for_snooper    = s_grant;
  assign ready_for_forwarder  = f_grant;
  assign vm_snooper_wr_addr   = snooper_wr_addr;
  assign vm_snooper_wr_data   = snooper_wr_data;
  assign vm_forwarder_rd_addr = forwarder_rd_addr;

  // Read data follows the held sel even after done, so a late read response still lands.
  assign forwarder_rd_data = vm_forwarder_rd_data[f_sel*DATA_WIDTH +: DATA_WIDTH];
  assign len_to_forwarder  = f_grant ? vm_len_to_forwarder[f_sel*SNOOP_FWD_ADDR_WIDTH +: SNOOP_FWD_ADDR_WIDTH]
                                     : '0;

  generate
    for (genvar gi = 0; gi < N_VMS; gi++) begin : g_strobe
      assign vm_snooper_wr_en[gi]   = s_grant && (s_sel == SW'(gi)) && snooper_wr_en;
      assign vm_snooper_done[gi]    = s_grant && (s_sel == SW'(gi)) && snooper_done;
      assign vm_forwarder_rd_en[gi] = f_grant && (f_sel == SW'(gi)) && forwarder_rd_en;
      assign vm_forwarder_done[gi]  = f_grant && (f_sel == SW'(gi)) && forwarder_done;
    end
  endgenerate
endmodule

// File: tb/tb_vm_dispatch.sv
// Directed bench for vm_dispatch: N_VMS=4, checks grants, strobes, counters and reset abort.
module tb_vm_dispatch;
  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] snooper_wr_addr = '0;
  logic [DW-1:0] snooper_wr_data = '0;
  logic          snooper_wr_en = 1'b0;
  logic          snooper_done = 1'b0;
  logic          ready_for_snooper;
  logic [AW-1:0] forwarder_rd_addr = '0;
  logic          forwarder_rd_en = 1'b0;
  logic          forwarder_done = 1'b0;
  logic [DW-1:0] forwarder_rd_data;
  logic          ready_for_forwarder;
  logic [AW-1:0] len_to_forwarder;
  logic [AW-1:0] vm_snooper_wr_addr;
  logic [DW-1:0] vm_snooper_wr_data;
  logic [N-1:0]  vm_snooper_wr_en;
  logic [N-1:0]  vm_snooper_done;
  logic [N-1:0]  vm_ready_for_snooper = '0;
  logic [AW-1:0] vm_forwarder_rd_addr;
  logic [N-1:0]  vm_forwarder_rd_en;
  logic [N-1:0]  vm_forwarder_done;
  logic [N*DW-1:0] vm_forwarder_rd_data;
  logic [N*AW-1:0] vm_len_to_forwarder;
  logic [N-1:0]  vm_ready_for_forwarder = '0;
  logic [31:0]   dispatch_count;
  logic [31:0]   forward_count;

  logic [DW-1:0] vm3_data = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // VM3 read port model: one-cycle read latency.
  always @(posedge clk) if (vm_forwarder_rd_en[3]) vm3_data <= 64'h0000_0000_DEAD_BEEF;

  assign vm_forwarder_rd_data = {vm3_data, 64'h2222, 64'h1111, 64'h0};
  assign vm_len_to_forwarder  = {9'd60, 9'd7, 9'd7, 9'd7};

  vm_dispatch #(.N_VMS(N), .SNOOP_FWD_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done),
    .ready_for_snooper(ready_for_snooper),
    .forwarder_rd_addr(forwarder_rd_addr), .forwarder_rd_en(forwarder_rd_en),
    .forwarder_done(forwarder_done), .forwarder_rd_data(forwarder_rd_data),
    .ready_for_forwarder(ready_for_forwarder), .len_to_forwarder(len_to_forwarder),
    .vm_snooper_wr_addr(vm_snooper_wr_addr), .vm_snooper_wr_data(vm_snooper_wr_data),
    .vm_snooper_wr_en(vm_snooper_wr_en), .vm_snooper_done(vm_snooper_done),
    .vm_ready_for_snooper(vm_ready_for_snooper),
    .vm_forwarder_rd_addr(vm_forwarder_rd_addr), .vm_forwarder_rd_en(vm_forwarder_rd_en),
    .vm_forwarder_done(vm_forwarder_done), .vm_forwarder_rd_data(vm_forwarder_rd_data),
    .vm_len_to_forwarder(vm_len_to_forwarder), .vm_ready_for_forwarder(vm_ready_for_forwarder),
    .dispatch_count(dispatch_count), .forward_count(forward_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_ready_snoop", ready_for_snooper, 0);
    chk("rst_ready_fwd", ready_for_forwarder, 0);
    chk("rst_len", len_to_forwarder, 0);
    chk("rst_dispatch_cnt", dispatch_count, 0);
    chk("rst_forward_cnt", forward_count, 0);
    rst = 1'b1;
    tick();

    // Pass-through of addresses and data
    snooper_wr_addr = 9'h1A5; snooper_wr_data = 64'h0123_4567_89AB_CDEF; forwarder_rd_addr = 9'h0F3;
    #1;
    chk("pt_wr_addr", vm_snooper_wr_addr, 9'h1A5);
    chk("pt_wr_data", vm_snooper_wr_data, 64'h0123_4567_89AB_CDEF);
    chk("pt_rd_addr", vm_forwarder_rd_addr, 9'h0F3);

    // Done and write while idle are ignored
    snooper_done = 1'b1; snooper_wr_en = 1'b1;
    #1;
    chk("idle_done", vm_snooper_done, 0);
    chk("idle_wr_en", vm_snooper_wr_en, 0);
    tick();
    snooper_done = 1'b0; snooper_wr_en = 1'b0;
    #1;
    chk("idle_cnt", dispatch_count, 0);
    chk("idle_ready", ready_for_snooper, 0);

    // Three packets, all VMs ready: VM0, VM1, VM2
    vm_ready_for_snooper = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_ready", ready_for_snooper, 1);
      snooper_wr_en = 1'b1;
      #1;
      chk("rr_wr_en", vm_snooper_wr_en, 64'(1) << k);
      snooper_wr_en = 1'b0; snooper_done = 1'b1;
      #1;
      chk("rr_done", vm_snooper_done, 64'(1) << k);
      tick();
      snooper_done = 1'b0;
      #1;
      chk("rr_no_regrant", ready_for_snooper, 0);
      chk("rr_cnt", dispatch_count, k + 1);
    end
    vm_ready_for_snooper = 4'b0000;
    tick();
    chk("rr_idle", ready_for_snooper, 0);

    // Write held before grant, only VM2 ready
    snooper_wr_en = 1'b1;
    tick();
    chk("pre_wr_en", vm_snooper_wr_en, 0);
    vm_ready_for_snooper = 4'b0100;
    #1;
    chk("pre_ready_same_cyc", ready_for_snooper, 0);
    tick();
    chk("vm2_ready", ready_for_snooper, 1);
    chk("vm2_wr_en", vm_snooper_wr_en, 4'b0100);
    vm_ready_for_snooper = 4'b0000;
    tick();
    chk("vm2_hold", vm_snooper_wr_en, 4'b0100);
    snooper_wr_en = 1'b0; snooper_done = 1'b1;
    #1;
    chk("vm2_done", vm_snooper_done, 4'b0100);
    tick();
    snooper_done = 1'b0;
    #1;
    chk("vm2_cnt", dispatch_count, 4);

    // Forwarder to VM3 with length and read data
    vm_ready_for_forwarder = 4'b1000;
    #1;
    chk("fwd_len_idle", len_to_forwarder, 0);
    tick();
    vm_ready_for_forwarder = 4'b0000;
    chk("fwd_ready", ready_for_forwarder, 1);
    chk("fwd_len", len_to_forwarder, 60);
    forwarder_rd_en = 1'b1;
    #1;
    chk("fwd_rd_en", vm_forwarder_rd_en, 4'b1000);
    tick();
    forwarder_rd_en = 1'b0;
    #1;
    chk("fwd_rd_data", forwarder_rd_data, 64'hDEAD_BEEF);
    forwarder_done = 1'b1;
    #1;
    chk("fwd_done", vm_forwarder_done, 4'b1000);
    tick();
    forwarder_done = 1'b0;
    #1;
    chk("fwd_cnt", forward_count, 1);
    chk("fwd_len_after", len_to_forwarder, 0);

    // Both sides on VM1, simultaneous done
    vm_ready_for_snooper = 4'b0010; vm_ready_for_forwarder = 4'b0010;
    tick();
    vm_ready_for_snooper = 4'b0000; vm_ready_for_forwarder = 4'b0000;
    chk("both_ready_s", ready_for_snooper, 1);
    chk("both_ready_f", ready_for_forwarder, 1);
    chk("both_len", len_to_forwarder, 7);
    snooper_done = 1'b1; forwarder_done = 1'b1;
    #1;
    chk("both_done_s", vm_snooper_done, 4'b0010);
    chk("both_done_f", vm_forwarder_done, 4'b0010);
    tick();
    snooper_done = 1'b0; forwarder_done = 1'b0;
    #1;
    chk("both_cnt_s", dispatch_count, 5);
    chk("both_cnt_f", forward_count, 2);

    // Reset mid-packet with sel=3 on both sides
    vm_ready_for_snooper = 4'b1000; vm_ready_for_forwarder = 4'b1000;
    tick();
    chk("pre_rst_ready", ready_for_snooper, 1);
    snooper_wr_en = 1'b1; forwarder_rd_en = 1'b1;
    #1;
    chk("pre_rst_wr_en", vm_snooper_wr_en, 4'b1000);
    snooper_done = 1'b1; forwarder_done = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_abort_ready_s", ready_for_snooper, 0);
    chk("rst_abort_ready_f", ready_for_forwarder, 0);
    chk("rst_abort_done_s", vm_snooper_done, 0);
    chk("rst_abort_done_f", vm_forwarder_done, 0);
    chk("rst_abort_wr_en", vm_snooper_wr_en, 0);
    chk("rst_abort_rd_en", vm_forwarder_rd_en, 0);
    chk("rst_abort_len", len_to_forwarder, 0);
    chk("rst_abort_cnt", dispatch_count, 0);
    snooper_done = 1'b0; forwarder_done = 1'b0;
    vm_ready_for_snooper = 4'b1111; vm_ready_for_forwarder = 4'b1111;
    tick();
    chk("rst_hold_ready", ready_for_snooper, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", ready_for_snooper, 1);
    chk("post_rst_wr_en", vm_snooper_wr_en, 4'b0001);
    chk("post_rst_rd_en", vm_forwarder_rd_en, 4'b0001);
    chk("post_rst_cnt", forward_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vm_dispatch.md
VM_DISPATCH -- requirements
Module: vm_dispatch

Interface
REQ-001 Parameter N_VMS, default 4, number of attached bpfvm instances (2..16).
REQ-002 Parameter SNOOP_FWD_ADDR_WIDTH, default 9, snooper/forwarder word-address width.
REQ-003 Parameter DATA_WIDTH, default 64, snooper/forwarder data width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 snooper_wr_addr / snooper_wr_data / snooper_wr_en  in  SNOOP_FWD_ADDR_WIDTH / DATA_WIDTH / 1  upstream write port.
REQ-007 snooper_done  in  1  1-cycle end-of-packet pulse. ready_for_snooper  out  1  a VM is granted to the snooper.
REQ-008 forwarder_rd_addr / forwarder_rd_en / forwarder_done  in  SNOOP_FWD_ADDR_WIDTH / 1 / 1  downstream read port; done is a 1-cycle pulse.
REQ-009 forwarder_rd_data / ready_for_forwarder / len_to_forwarder  out  DATA_WIDTH / 1 / SNOOP_FWD_ADDR_WIDTH  downstream read result, grant, and length.
REQ-010 vm_snooper_wr_addr / vm_snooper_wr_data  out  SNOOP_FWD_ADDR_WIDTH / DATA_WIDTH  broadcast to all VMs. vm_snooper_wr_en / vm_snooper_done  out  N_VMS  per-VM strobes.
REQ-011 vm_ready_for_snooper  in  N_VMS  per-VM ready flags. vm_forwarder_rd_addr  out  SNOOP_FWD_ADDR_WIDTH  broadcast. vm_forwarder_rd_en / vm_forwarder_done  out  N_VMS  per-VM strobes.
REQ-012 vm_forwarder_rd_data  in  N_VMS*DATA_WIDTH, VM i at bits [i*DATA_WIDTH +: DATA_WIDTH]. vm_len_to_forwarder  in  N_VMS*SNOOP_FWD_ADDR_WIDTH, packed the same way. vm_ready_for_forwarder  in  N_VMS.
REQ-013 dispatch_count / forward_count  out  32 / 32  completed snooper packets / completed forwarder packets.

Function
REQ-014 The snooper side and the forwarder side each SHALL be an independent two-state FSM, S_IDLE and S_GRANT, with registers sel (clog2(N_VMS) bits) and rr_ptr.
REQ-015 In S_IDLE, when any ready bit is set, the FSM SHALL latch sel = the first set index at or after rr_ptr, scanning upward with wrap, and move to S_GRANT on the next edge; grant latency is exactly 1 cycle.
REQ-016 ready_for_snooper and ready_for_forwarder SHALL be registered and high exactly while the respective FSM is in S_GRANT.
REQ-017 In S_GRANT: vm_snooper_wr_en[sel] = snooper_wr_en, and vm_forwarder_rd_en[sel] = forwarder_rd_en. All other bits are 0, and all bits are 0 outside S_GRANT.
REQ-018 vm_snooper_done[sel] SHALL equal snooper_done combinationally in S_GRANT. On that same edge the FSM SHALL return to S_IDLE, rr_ptr SHALL become sel+1 mod N_VMS, and dispatch_count SHALL increment by 1.
REQ-019 forwarder_done SHALL follow the REQ-018 rule on the forwarder side, driving vm_forwarder_done[sel] and incrementing forward_count.
REQ-020 forwarder_rd_data SHALL be vm_forwarder_rd_data[sel], muxed combinationally from the held sel, so the VM's 1-cycle read latency passes through unchanged. In S_GRANT, len_to_forwarder SHALL be the sel slice of vm_len_to_forwarder; otherwise it is 0.
REQ-021 vm_snooper_wr_addr/data and vm_forwarder_rd_addr SHALL be direct pass-throughs of the upstream ports.
REQ-022 Writes, reads, and done pulses arriving while their FSM is in S_IDLE SHALL be ignored: no VM strobe, no counter change, no state change.
REQ-023 Once granted, sel SHALL be held until done, even if the granted VM's ready bit drops.
REQ-024 No re-grant SHALL occur in the done cycle. The next grant needs at least one S_IDLE cycle, so packet-to-packet turnaround is at least 2 cycles.
REQ-025 Both counters SHALL wrap modulo 2^32.
REQ-026 The two sides MAY grant the same VM at the same time; this is legal because packetmem ping-pongs buffers. The block gives no ordering guarantee between dispatch and forward.

Reset
REQ-027 While rst=0, both FSMs SHALL be in S_IDLE, and sel, rr_ptr, both counters, both ready outputs, all per-VM strobes, and len_to_forwarder SHALL be 0.
REQ-028 Reset asserted mid-packet SHALL abort the grant immediately, without emitting a done pulse to the VM. After rst returns high, arbitration SHALL resume from rr_ptr=0.

Verification
REQ-029 Scenario: N_VMS=4, vm_ready_for_snooper=4'b1111, and three packets each ending in snooper_done -> grants go to VM0, VM1, VM2 in order; each packet's wr_en appears only on its own VM's bit; dispatch_count=3.
REQ-030 Scenario: vm_ready_for_snooper=4'b0100, then snooper_wr_en held high before the grant -> no vm_snooper_wr_en until ready_for_snooper=1, which occurs 1 cycle after the ready bit is seen; sel=2.
REQ-031 Scenario: vm_ready_for_forwarder=4'b1000, vm_len_to_forwarder slice 3 = 60, VM3 returns data 0xDEADBEEF one cycle after rd_en -> len_to_forwarder=60, and forwarder_rd_data=0xDEADBEEF on the same cycle VM3 presents it.
REQ-032 Scenario: both sides granted to VM1 concurrently, then snooper_done and forwarder_done in the same cycle -> vm_snooper_done=4'b0010 and vm_forwarder_done=4'b0010; both counters increment.
REQ-033 Scenario: rst pulled low during S_GRANT with sel=3 -> all outputs 0 asynchronously and no vm_*_done pulse; after release with all VMs ready, the next grant is VM0.
REQ-034 Scenario: snooper_done pulse while in S_IDLE -> vm_snooper_done=0 and dispatch_count unchanged.
